lcd_char_ctrl: RTL
==================

Name: lcd_char_ctrl

Overview:
Parametrised HD44780-class character-LCD controller. Successor to the fixed 4-bit controller. Adds selectable 4/8-bit bus, configurable geometry, and cursor tracking with automatic line wrap. It also adds a valid/ready character stream plus clear and goto requests. Sits between message FSMs and LCD board pins; write-only (RW tied low).

Parameters:
BUS_W, 4, LCD data bus width; legal values 4 or 8
ROWS, 2, display rows (1..4)
COLS, 16, display columns (1..40)
T_PWR, 750000, cycles from reset release to first init write (15 ms @ 50 MHz)
T_AS, 2, cycles RS/DB stable before E rises
T_PW, 12, E high width in cycles
T_H, 2, cycles RS/DB held after E falls
T_INIT1, 205000, wait after first 0x3 init write (4.1 ms)
T_CMD, 2000, execution wait after normal command/data (40 us)
T_CLR, 82000, execution wait after clear (1.64 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
char_valid  in  1  char_data valid
char_data  in  8  ASCII/CGROM code to write at cursor
char_ready  out  1  controller accepts char this cycle
clear_req  in  1  level/pulse; clear display, cursor to (0,0)
goto_req  in  1  move cursor
goto_row  in  2  target row
goto_col  in  6  target column
init_done  out  1  init sequence complete (sticky until rst)
busy  out  1  high whenever not in IDLE
cur_row  out  2  current cursor row
cur_col  out  6  current cursor column
lcd_rs  out  1  register select
lcd_rw  out  1  constant 0
lcd_e  out  1  enable strobe
lcd_db  out  BUS_W  data bus (upper nibble first in 4-bit mode)

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, char_ready=0, init_done=0, busy=1, cur_row=0, cur_col=0.
- Reset mid-operation aborts any transfer; E low the same edge; full init re-runs.
- Transfer unit (one bus write):
  - cycle 0: drive RS/DB;
  - E high from cycle T_AS for T_PW cycles;
  - then T_H hold cycles with E low.
  - 8-bit mode: one unit per byte.
  - 4-bit mode: two units per byte, byte[7:4] then byte[3:0].
  - After the byte completes, wait T_CMD (T_CLR for 0x01) before the next action.
- Main FSM: PWR_WAIT -> INIT (step counter) -> IDLE <-> XFER -> EXEC_WAIT -> IDLE.
- INIT, 4-bit bus:
  - single-nibble writes 0x3 (wait T_INIT1), 0x3 (wait T_CMD), 0x3 (T_CMD), 0x2 (T_CMD);
  - then full bytes FUNC=0x20|N<<3, 0x0C, 0x06, 0x01 (T_CLR).
- INIT, 8-bit bus: 0x30, 0x30, 0x30 with the same waits, then FUNC=0x30|N<<3, 0x0C, 0x06, 0x01.
- N=1 iff ROWS>1. init_done rises the cycle IDLE is first entered.
- IDLE priority: clear_req > goto_req > char.
  - char_ready = (state==IDLE) & !clear_req & !goto_req.
  - A char is accepted on char_valid&char_ready; char_ready is 0 the next cycle.
  - clear_req/goto_req sampled only in IDLE, consumed on entry to XFER.
- clear: send 0x01 (RS=0); cur_row/cur_col <= 0.
- goto:
  - col>=COLS clamps to COLS-1; row>=ROWS clamps to ROWS-1.
  - send 0x80|addr with addr = row_base[row]+col; row_base = {0x00,0x40,0x14,0x54}; COLS>20 uses row_base {0x00,0x40} only.
  - cursor updated to the clamped values.
- char:
  - if cur_col==COLS: first send set-address to ((cur_row+1) mod ROWS, 0), then the data byte with RS=1.
  - then cur_col <= cur_col+1; the wrap is deferred, so the last column is written without an extra command.
  - char_ready stays low across both transfers.
- cur_col may equal COLS only transiently, between the last-column write and the next char; goto/clear override it.
- Simultaneous clear_req and char_valid: clear wins, char is not accepted (char_ready=0).

Decomposition:
- Shared package lcd_pkg holds:
  - command constants: CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_DISP_ON=0x0C, CMD_FUNC_BASE, CMD_SET_DDRAM=0x80;
  - row_base table;
  - FSM state enum.
- One sub-module, lcd_bus_xfer: takes start, rs, byte, nibble_only; produces lcd_rs/lcd_e/lcd_db timing and a done pulse; parametrised by BUS_W, T_AS, T_PW, T_H.
- Top module holds the init ROM, wait counter, cursor, and request arbitration.

Test Plan:
- Bench parameters for all scenarios: T_PWR=20, T_INIT1=10, T_CMD=5, T_CLR=8, T_AS=1, T_PW=2, T_H=1.
- Init 4-bit, ROWS=2: rst 2 cycles -> E-strobed nibble sequence 3,3,3,2,2,8,0,C,0,6,0,1 with RS=0; init_done=1 after the final T_CLR wait; busy=0.
- Init 8-bit, ROWS=1: -> bytes 0x30,0x30,0x30,0x30,0x0C,0x06,0x01; N bit clear.
- Char stream 4-bit, COLS=4, ROWS=2: write "ABCDE" -> data 0x41..0x44 at RS=1, then cmd 0xC0 (RS=0), then 0x45; cur_row=1, cur_col=1.
- Wrap from last row: ROWS=2, cursor (1,COLS) then 'Z' -> cmd 0x80 then 0x5A; cur_row=0, cur_col=1.
- Goto clamp plus priority: goto_req (row 3, col 50) with COLS=16, ROWS=2 -> cmd 0xCF; cursor (1,15). Same cycle as char_valid -> char_ready=0 until goto completes.
- Reset mid-transfer: assert rst while lcd_e=1 -> next edge lcd_e=0, init_done=0, busy=1; after T_PWR the init sequence restarts from the first 0x3.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller: HD44780 command bytes,
// DDRAM row base addresses, main FSM state encoding and the post-write wait
// selector.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_FUNC_BASE = 8'h20;  // function set, DL=0
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CMD_WAKE      = 8'h30;  // wake-up write during init
  localparam logic [7:0] CMD_4BIT      = 8'h20;  // switch interface to 4 bits

  localparam logic [7:0] FUNC_DL = 8'h10;  // 8-bit interface
  localparam logic [7:0] FUNC_N  = 8'h08;  // two-line display

  typedef enum logic [2:0] {
    StPwrWait,
    StInit,
    StIdle,
    StXfer,
    StExecWait
  } lcd_state_e;

  typedef enum logic [1:0] {
    WaitCmd,
    WaitClr,
    WaitInit1
  } wait_sel_e;

  // Wide panels (more than 20 columns) only have two DDRAM lines.
  function automatic logic [6:0] row_base(input logic [1:0] row, input logic wide);
    logic [6:0] base;
    if (wide) begin
      base = row[0] ? 7'h40 : 7'h00;
    end else begin
      case (row)
        2'd0:    base = 7'h00;
        2'd1:    base = 7'h40;
        2'd2:    base = 7'h14;
        default: base = 7'h54;
      endcase
    end
    return base;
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One LCD bus write with HD44780 setup/strobe/hold timing.
// A write is one or two units; each unit: RS/DB driven at cycle 0, E high
// from cycle T_AS for T_PW cycles, then T_H cycles with E low.
// 4-bit bus sends byte[7:4] then byte[3:0] unless nibble_only (byte[7:4] only).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a write (sampled only while idle)
//   rs, data      register select and byte to send
//   nibble_only   4-bit bus: send only data[7:4] (ignored on 8-bit bus)
//   lcd_rs/lcd_e/lcd_db  board pins
//   done          high in the final cycle of the write
module lcd_bus_xfer #(
  parameter int unsigned BUS_W = 4,
  parameter int unsigned T_AS  = 2,
  parameter int unsigned T_PW  = 12,
  parameter int unsigned T_H   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rs,
  input  logic [7:0]       data,
  input  logic             nibble_only,
  output logic             lcd_rs,
  output logic             lcd_e,
  output logic [BUS_W-1:0] lcd_db,
  output logic             done
);

  localparam int unsigned Unit = T_AS + T_PW + T_H;
  localparam int unsigned CntW = (Unit > 1) ? $clog2(Unit + 1) : 1;
  localparam logic [CntW-1:0] EOn   = CntW'(T_AS);
  localparam logic [CntW-1:0] EOff  = CntW'(T_AS + T_PW);
  localparam logic [CntW-1:0] Last  = CntW'(Unit - 1);

  logic             active_q, active_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             second_q, second_d;
  logic [BUS_W-1:0] low_q, low_d;
  logic             rs_q, rs_d;
  logic [BUS_W-1:0] db_q, db_d;
  logic             e_q, e_d;

  logic [BUS_W-1:0] first_part, low_part;
  logic             two_units;

  if (BUS_W == 8) begin : g_bus8
    assign first_part = data;
    assign low_part   = data;
    assign two_units  = 1'b0;
  end else begin : g_bus4
    assign first_part = data[7:4];
    assign low_part   = data[3:0];
    assign two_units  = !nibble_only;
  end

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    second_d = second_q;
    low_d    = low_q;
    rs_d     = rs_q;
    db_d     = db_q;
    done     = 1'b0;
    if (start && !active_q) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rs_d     = rs;
      db_d     = first_part;
      low_d    = low_part;
      second_d = two_units;
    end else if (active_q) begin
      if (cnt_q == Last) begin
        if (second_q) begin
          cnt_d    = '0;
          second_d = 1'b0;
          db_d     = low_q;
        end else begin
          active_d = 1'b0;
          done     = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // E is registered from the next count so it stays glitch-free on the pin.
    e_d = active_d && (cnt_d >= EOn) && (cnt_d < EOff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      second_q <= 1'b0;
      low_q    <= '0;
      rs_q     <= 1'b0;
      db_q     <= '0;
      e_q      <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      second_q <= second_d;
      low_q    <= low_d;
      rs_q     <= rs_d;
      db_q     <= db_d;
      e_q      <= e_d;
    end
  end

  assign lcd_rs = rs_q;
  assign lcd_e  = e_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780-class character LCD controller (write-only).
// Runs the power-up init sequence, then serves clear, goto and a valid/ready
// character stream while tracking the cursor with deferred line wrap.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   char_valid/char_data     character stream in; char_ready accepts
//   clear_req                clear display, cursor to (0,0)
//   goto_req/goto_row/col    move cursor (clamped to the geometry)
//   init_done                sticky once init completes
//   busy                     high whenever not idle
//   cur_row/cur_col          cursor position
//   lcd_rs/lcd_rw/lcd_e/lcd_db  board pins (lcd_rw tied low)
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned BUS_W   = 4,
  parameter int unsigned ROWS    = 2,
  parameter int unsigned COLS    = 16,
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_AS    = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_H     = 2,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  input  logic             clear_req,
  input  logic             goto_req,
  input  logic [1:0]       goto_row,
  input  logic [5:0]       goto_col,
  output logic             init_done,
  output logic             busy,
  output logic [1:0]       cur_row,
  output logic [5:0]       cur_col,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_e,
  output logic [BUS_W-1:0] lcd_db
);

  // Counters load T-1 and leave their state when they reach zero.
  localparam logic [31:0] WaitPwr   = 32'(T_PWR - 1);
  localparam logic [31:0] WaitInit  = 32'(T_INIT1 - 1);
  localparam logic [31:0] WaitCmdV  = 32'(T_CMD - 1);
  localparam logic [31:0] WaitClrV  = 32'(T_CLR - 1);

  localparam logic [1:0] LastRow = 2'(ROWS - 1);
  localparam logic [5:0] ColsV   = 6'(COLS);
  localparam logic [5:0] LastCol = 6'(COLS - 1);
  localparam logic       Wide    = (COLS > 20);
  localparam logic [7:0] CmdFunc = CMD_FUNC_BASE | ((BUS_W == 8) ? FUNC_DL : 8'h00)
                                   | ((ROWS > 1) ? FUNC_N : 8'h00);
  localparam logic [2:0] LastStep = 3'd7;

  lcd_state_e  state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [2:0]  step_q, step_d;
  logic        init_done_q, init_done_d;
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_data_q, pend_data_d;
  wait_sel_e   xwait_q, xwait_d;

  logic        x_start, x_rs, x_nib, x_done;
  logic [7:0]  x_data;

  logic [7:0]  rom_data;
  logic        rom_nib;
  wait_sel_e   rom_wait;

  logic [1:0]  next_row, goto_row_c;
  logic [5:0]  goto_col_c;
  logic [6:0]  goto_addr;
  logic [31:0] exec_len;

  // Init ROM; steps 0..3 are single-nibble writes on a 4-bit bus.
  always_comb begin
    rom_data = CMD_CLEAR;
    rom_nib  = 1'b0;
    rom_wait = WaitCmd;
    case (step_q)
      3'd0: begin
        rom_data = CMD_WAKE;
        rom_nib  = 1'b1;
        rom_wait = WaitInit1;
      end
      3'd1, 3'd2: begin
        rom_data = CMD_WAKE;
        rom_nib  = 1'b1;
      end
      3'd3: begin
        rom_data = CMD_4BIT;
        rom_nib  = 1'b1;
      end
      3'd4:    rom_data = CmdFunc;
      3'd5:    rom_data = CMD_DISP_ON;
      3'd6:    rom_data = CMD_ENTRY;
      default: rom_wait = WaitClr;
    endcase
  end

  always_comb begin
    case (xwait_q)
      WaitClr:   exec_len = WaitClrV;
      WaitInit1: exec_len = WaitInit;
      default:   exec_len = WaitCmdV;
    endcase
  end

  assign next_row   = (row_q >= LastRow) ? 2'd0 : row_q + 2'd1;
  assign goto_row_c = (goto_row > LastRow) ? LastRow : goto_row;
  assign goto_col_c = (goto_col > LastCol) ? LastCol : goto_col;
  assign goto_addr  = row_base(goto_row_c, Wide) + {1'b0, goto_col_c};

  assign char_ready = (state_q == StIdle) && !clear_req && !goto_req;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    row_d       = row_q;
    col_d       = col_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    xwait_d     = xwait_q;
    x_start     = 1'b0;
    x_rs        = 1'b0;
    x_data      = 8'h00;
    x_nib       = 1'b0;
    case (state_q)
      StPwrWait: begin
        if (wait_q == 32'd0) state_d = StInit;
        else wait_d = wait_q - 32'd1;
      end
      StInit: begin
        x_start = 1'b1;
        x_data  = rom_data;
        x_nib   = rom_nib;
        xwait_d = rom_wait;
        state_d = StXfer;
      end
      StIdle: begin
        if (clear_req) begin
          x_start = 1'b1;
          x_data  = CMD_CLEAR;
          xwait_d = WaitClr;
          row_d   = 2'd0;
          col_d   = 6'd0;
          state_d = StXfer;
        end else if (goto_req) begin
          x_start = 1'b1;
          x_data  = CMD_SET_DDRAM | {1'b0, goto_addr};
          xwait_d = WaitCmd;
          row_d   = goto_row_c;
          col_d   = goto_col_c;
          state_d = StXfer;
        end else if (char_valid) begin
          x_start = 1'b1;
          xwait_d = WaitCmd;
          state_d = StXfer;
          if (col_q == ColsV) begin
            // Deferred wrap: reposition first, the character follows the wait.
            x_data      = CMD_SET_DDRAM | {1'b0, row_base(next_row, Wide)};
            pend_d      = 1'b1;
            pend_data_d = char_data;
            row_d       = next_row;
            col_d       = 6'd1;
          end else begin
            x_rs   = 1'b1;
            x_data = char_data;
            col_d  = col_q + 6'd1;
          end
        end
      end
      StXfer: begin
        if (x_done) begin
          wait_d  = exec_len;
          state_d = StExecWait;
        end
      end
      StExecWait: begin
        if (wait_q != 32'd0) begin
          wait_d = wait_q - 32'd1;
        end else if (!init_done_q) begin
          if (step_q == LastStep) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            // An 8-bit bus has no nibble-mode switch step.
            step_d  = (BUS_W == 8 && step_q == 3'd2) ? 3'd4 : step_q + 3'd1;
            state_d = StInit;
          end
        end else if (pend_q) begin
          x_start = 1'b1;
          x_rs    = 1'b1;
          x_data  = pend_data_q;
          xwait_d = WaitCmd;
          pend_d  = 1'b0;
          state_d = StXfer;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StPwrWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPwrWait;
      wait_q      <= WaitPwr;
      step_q      <= 3'd0;
      init_done_q <= 1'b0;
      row_q       <= 2'd0;
      col_q       <= 6'd0;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      xwait_q     <= WaitCmd;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      xwait_q     <= xwait_d;
    end
  end

  lcd_bus_xfer #(
    .BUS_W (BUS_W),
    .T_AS  (T_AS),
    .T_PW  (T_PW),
    .T_H   (T_H)
  ) u_bus (
    .clk         (clk),
    .rst         (rst),
    .start       (x_start),
    .rs          (x_rs),
    .data        (x_data),
    .nibble_only (x_nib),
    .lcd_rs      (lcd_rs),
    .lcd_e       (lcd_e),
    .lcd_db      (lcd_db),
    .done        (x_done)
  );

  assign init_done = init_done_q;
  assign busy      = (state_q != StIdle);
  assign cur_row   = row_q;
  assign cur_col   = col_q;
  assign lcd_rw    = 1'b0;

endmodule
